// File: rtl/phr_pkg.sv
// Shared types and width helpers for the packet-header read engine.
package phr_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam int DROP_W = 16;

    function automatic int fid_w(input int flow_num);
        return $clog2(flow_num);
    endfunction

    function automatic int beat_w(input int hdr_beats);
        return (hdr_beats > 1) ? $clog2(hdr_beats) : 1;
    endfunction

    function automatic int addr_w(input int flow_num, input int hdr_beats);
        return 1 + fid_w(flow_num) + beat_w(hdr_beats);
    endfunction

endpackage

// File: rtl/phr_arbiter.sv
// Flow arbiter: fixed lowest-index priority, or round-robin when PHR_RR_ARB_EN is defined.
module phr_arbiter
    import phr_pkg::*;
#(
    parameter  int FLOW_NUM = 8,
    localparam int FID_W    = fid_w(FLOW_NUM)
) (
`ifdef PHR_RR_ARB_EN
    input  logic                clk,
    input  logic                rst_n,
    input  logic                adv,
`endif
    input  logic [FLOW_NUM-1:0] req,
    output logic [FLOW_NUM-1:0] grant,
    output logic [FID_W-1:0]    grant_idx
);

`ifdef PHR_RR_ARB_EN
    logic [FID_W-1:0] ptr;
    logic [FID_W-1:0] idx;
    logic             found;

    // Pointer starts at the top index so that flow 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   ptr <= FID_W'(FLOW_NUM - 1);
        else if (adv) ptr <= grant_idx;
    end

    // FLOW_NUM is a power of two, so the index wraps naturally.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 0; i < FLOW_NUM; i++) begin
            idx = ptr + FID_W'(i + 1);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end
`else
    // Descending scan: the last hit written is the lowest requesting index.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int i = FLOW_NUM - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = FID_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/pkt_hdr_reader.sv
// Header-read engine: queues flow requests, issues back-to-back RAM reads per header and
// retimes the returned beats with flow/last tags. Arbitration mode selected by PHR_RR_ARB_EN.
module pkt_hdr_reader
    import phr_pkg::*;
#(
    parameter  int FLOW_NUM  = 8,
    parameter  int HDR_BEATS = 4,
    parameter  int DATA_W    = 128,
    parameter  int RD_LAT    = 2,
    localparam int FID_W     = fid_w(FLOW_NUM),
    localparam int BEAT_W    = beat_w(HDR_BEATS),
    localparam int ADDR_W    = addr_w(FLOW_NUM, HDR_BEATS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_addr_shift,
    input  logic [FLOW_NUM-1:0] in_selected,
    output logic                out_pkt_hdr_rd,
    output logic [ADDR_W-1:0]   out_pkt_hdr_addr,
    input  logic [DATA_W-1:0]   in_pkt_hdr,
    output logic [DATA_W-1:0]   out_pkt_hdr,
    output logic                out_pkt_hdr_wr,
    output logic                out_pkt_hdr_last,
    output logic [FID_W-1:0]    out_pkt_hdr_flow,
    output logic                out_busy,
    output logic [DROP_W-1:0]   out_drop_cnt
);

    state_t              state, state_nx;
    logic [BEAT_W-1:0]   beat, beat_nx;
    logic [FID_W-1:0]    flow_q, flow_nx;
    logic                bank_q, bank_nx;
    logic                take;
    logic                last_beat;
    logic [FLOW_NUM-1:0] pend, grant, grant_clr;
    logic [FID_W-1:0]    grant_idx;
    logic                drop_hit;

    logic [RD_LAT-1:0]   pipe_v, pipe_l;
    logic [FID_W-1:0]    pipe_f [RD_LAT];

    phr_arbiter #(.FLOW_NUM(FLOW_NUM)) u_arb (
`ifdef PHR_RR_ARB_EN
        .clk       (clk),
        .rst_n     (rst_n),
        .adv       (take),
`endif
        .req       (pend),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign last_beat = (beat == BEAT_W'(HDR_BEATS - 1));
    assign grant_clr = take ? grant : '0;
    assign drop_hit  = |(in_selected & pend & ~grant_clr);
    assign out_busy  = (state == ISSUE) | (|pend) | (|pipe_v);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            beat   <= '0;
            flow_q <= '0;
            bank_q <= 1'b0;
        end else begin
            state  <= state_nx;
            beat   <= beat_nx;
            flow_q <= flow_nx;
            bank_q <= bank_nx;
        end
    end

    // A grant on the last beat chains straight into the next header with no bubble.
    always_comb begin
        state_nx         = state;
        beat_nx          = beat;
        flow_nx          = flow_q;
        bank_nx          = bank_q;
        take             = 1'b0;
        out_pkt_hdr_rd   = 1'b0;
        out_pkt_hdr_addr = '0;
        case (state)
            IDLE: begin
                if (|pend) begin
                    take     = 1'b1;
                    state_nx = ISSUE;
                    beat_nx  = '0;
                    flow_nx  = grant_idx;
                    bank_nx  = in_addr_shift;
                end
            end
            ISSUE: begin
                out_pkt_hdr_rd   = 1'b1;
                out_pkt_hdr_addr = {bank_q, flow_q, beat};
                if (last_beat) begin
                    beat_nx = '0;
                    if (|pend) begin
                        take    = 1'b1;
                        flow_nx = grant_idx;
                        bank_nx = in_addr_shift;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    beat_nx = beat + BEAT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // New requests override the grant clear, so a same-cycle re-request is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend         <= '0;
            out_drop_cnt <= '0;
        end else begin
            pend <= (pend & ~grant_clr) | in_selected;
            if (drop_hit && (out_drop_cnt != {DROP_W{1'b1}}))
                out_drop_cnt <= out_drop_cnt + DROP_W'(1);
        end
    end

    // Tags travel alongside the RAM access so they line up with returning data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v <= '0;
            pipe_l <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_f[i] <= '0;
        end else begin
            pipe_v[0] <= out_pkt_hdr_rd;
            pipe_l[0] <= out_pkt_hdr_rd & last_beat;
            pipe_f[0] <= out_pkt_hdr_rd ? flow_q : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_l[i] <= pipe_l[i-1];
                pipe_f[i] <= pipe_f[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pkt_hdr      <= '0;
            out_pkt_hdr_wr   <= 1'b0;
            out_pkt_hdr_last <= 1'b0;
            out_pkt_hdr_flow <= '0;
        end else begin
            out_pkt_hdr      <= pipe_v[RD_LAT-1] ? in_pkt_hdr : '0;
            out_pkt_hdr_wr   <= pipe_v[RD_LAT-1];
            out_pkt_hdr_last <= pipe_l[RD_LAT-1];
            out_pkt_hdr_flow <= pipe_f[RD_LAT-1];
        end
    end

endmodule

// File: tb/tb_pkt_hdr_reader.sv
// Bench for pkt_hdr_reader: default instance driven from a cycle table plus corner sequences,
// and a wider instance (16 flows, 8 beats, latency 4) for latency and address format.
module tb_pkt_hdr_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic         shift = 1'b0;
    logic [7:0]   sel = '0;
    logic         rd, wr, last, busy;
    logic [5:0]   addr;
    logic [127:0] ram, data;
    logic [2:0]   flow;
    logic [15:0]  drop;

    // wide instance
    logic         shift2 = 1'b0;
    logic [15:0]  sel2 = '0;
    logic         rd2, wr2, last2, busy2;
    logic [7:0]   addr2;
    logic [127:0] ram2, data2;
    logic [3:0]   flow2;
    logic [15:0]  drop2;

    pkt_hdr_reader u_dut (
        .clk (clk), .rst_n (rst_n), .in_addr_shift (shift), .in_selected (sel),
        .out_pkt_hdr_rd (rd), .out_pkt_hdr_addr (addr), .in_pkt_hdr (ram),
        .out_pkt_hdr (data), .out_pkt_hdr_wr (wr), .out_pkt_hdr_last (last),
        .out_pkt_hdr_flow (flow), .out_busy (busy), .out_drop_cnt (drop)
    );

    pkt_hdr_reader #(.FLOW_NUM(16), .HDR_BEATS(8), .DATA_W(128), .RD_LAT(4)) u_big (
        .clk (clk), .rst_n (rst_n), .in_addr_shift (shift2), .in_selected (sel2),
        .out_pkt_hdr_rd (rd2), .out_pkt_hdr_addr (addr2), .in_pkt_hdr (ram2),
        .out_pkt_hdr (data2), .out_pkt_hdr_wr (wr2), .out_pkt_hdr_last (last2),
        .out_pkt_hdr_flow (flow2), .out_busy (busy2), .out_drop_cnt (drop2)
    );

    function automatic logic [127:0] ram_word(input logic [7:0] a);
        return {4{24'hC0FFEE, a}} ^ {a, 120'h0};
    endfunction

    // RAM models: data for an address appears RD_LAT cycles after the read cycle
    logic [5:0] ah [2] = '{6'd0, 6'd0};
    logic [7:0] bh [4] = '{8'd0, 8'd0, 8'd0, 8'd0};
    always @(posedge clk) begin
        ah[0] <= addr;  ah[1] <= ah[0];
        bh[0] <= addr2; bh[1] <= bh[0]; bh[2] <= bh[1]; bh[3] <= bh[2];
    end
    assign ram  = ram_word({2'b00, ah[1]});
    assign ram2 = ram_word(bh[3]);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // header and beat counters on the default instance
    int last_cnt [8];
    int wr_cnt = 0;
    always @(negedge clk) begin
        if (wr) wr_cnt++;
        if (wr && last) last_cnt[flow]++;
    end

    task automatic clear_cnt();
        for (int i = 0; i < 8; i++) last_cnt[i] = 0;
        wr_cnt = 0;
    endtask

    // read-address scoreboard
    logic [5:0] exp_q [$];
    bit sb_en = 1'b0;
    always @(negedge clk) begin
        if (sb_en && rd) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rd_addr_sb: unexpected read addr %0h, expected none", addr);
            end else begin
                check("rd_addr_sb", {122'd0, addr}, {122'd0, exp_q.pop_front()});
            end
        end
    end

    typedef struct {
        logic [7:0] sel;
        logic       shift;
        logic       rd;
        logic [5:0] addr;
        logic       wr;
        logic       last;
        logic [2:0] flow;
        logic [5:0] daddr;
        logic       busy;
    } vec_t;
    vec_t vt [$];

    task automatic add(input logic [7:0] s, input logic sh, input logic r, input logic [5:0] a,
                       input logic w, input logic l, input logic [2:0] f, input logic [5:0] d,
                       input logic b);
        vec_t v;
        v = '{s, sh, r, a, w, l, f, d, b};
        vt.push_back(v);
    endtask

    task automatic cyc(input logic [7:0] s);
        @(negedge clk);
        sel = s;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_idle: busy still %0b after 200 cycles, required 0", busy);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd"},   rd,   1'b0);
        check({tag, "_addr"}, addr, 6'h0);
        check({tag, "_wr"},   wr,   1'b0);
        check({tag, "_last"}, last, 1'b0);
        check({tag, "_flow"}, flow, 3'h0);
        check({tag, "_data"}, data, 128'h0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_drop"}, drop, 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_rd, first_wr, nrd, nwr;

        // flow 2, bank 1, single header
        add(8'h04,1, 0,6'h00, 0,0,3'd0,6'h00, 0);
        add(8'h00,1, 0,6'h00, 0,0,3'd0,6'h00, 1);
        add(8'h00,1, 1,6'h28, 0,0,3'd0,6'h00, 1);
        add(8'h00,1, 1,6'h29, 0,0,3'd0,6'h00, 1);
        add(8'h00,1, 1,6'h2A, 0,0,3'd0,6'h00, 1);
        add(8'h00,1, 1,6'h2B, 1,0,3'd2,6'h28, 1);
        add(8'h00,1, 0,6'h00, 1,0,3'd2,6'h29, 1);
        add(8'h00,1, 0,6'h00, 1,0,3'd2,6'h2A, 1);
        add(8'h00,1, 0,6'h00, 1,1,3'd2,6'h2B, 0);
        add(8'h00,1, 0,6'h00, 0,0,3'd0,6'h00, 0);
        // multi-hot 0x81: flow 0 then flow 7 back-to-back, bank 0
        add(8'h81,0, 0,6'h00, 0,0,3'd0,6'h00, 0);
        add(8'h00,0, 0,6'h00, 0,0,3'd0,6'h00, 1);
        add(8'h00,0, 1,6'h00, 0,0,3'd0,6'h00, 1);
        add(8'h00,0, 1,6'h01, 0,0,3'd0,6'h00, 1);
        add(8'h00,0, 1,6'h02, 0,0,3'd0,6'h00, 1);
        add(8'h00,0, 1,6'h03, 1,0,3'd0,6'h00, 1);
        add(8'h00,0, 1,6'h1C, 1,0,3'd0,6'h01, 1);
        add(8'h00,0, 1,6'h1D, 1,0,3'd0,6'h02, 1);
        add(8'h00,0, 1,6'h1E, 1,1,3'd0,6'h03, 1);
        add(8'h00,0, 1,6'h1F, 1,0,3'd7,6'h1C, 1);
        add(8'h00,0, 0,6'h00, 1,0,3'd7,6'h1D, 1);
        add(8'h00,0, 0,6'h00, 1,0,3'd7,6'h1E, 1);
        add(8'h00,0, 0,6'h00, 1,1,3'd7,6'h1F, 0);
        add(8'h00,0, 0,6'h00, 0,0,3'd0,6'h00, 0);

        clear_cnt();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        check("reset_big_rd", rd2, 1'b0);
        check("reset_big_wr", wr2, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            sel   = vt[i].sel;
            shift = vt[i].shift;
            check($sformatf("v%0d_rd", i),   rd,   vt[i].rd);
            check($sformatf("v%0d_addr", i), addr, vt[i].rd ? vt[i].addr : 6'h0);
            check($sformatf("v%0d_wr", i),   wr,   vt[i].wr);
            check($sformatf("v%0d_last", i), last, vt[i].last);
            check($sformatf("v%0d_flow", i), flow, vt[i].flow);
            check($sformatf("v%0d_data", i), data,
                  vt[i].wr ? ram_word({2'b00, vt[i].daddr}) : 128'h0);
            check($sformatf("v%0d_busy", i), busy, vt[i].busy);
        end
        cyc(8'h00);
        shift = 1'b0;
        wait_idle();

        // drop: flow 3 re-requested while pending behind flow 0
        clear_cnt();
        cyc(8'h01); cyc(8'h00); cyc(8'h08); cyc(8'h08); cyc(8'h00);
        wait_idle();
        check("drop_pending", drop, 16'd1);
        check("drop_flow0_hdrs", last_cnt[0], 1);
        check("drop_flow3_hdrs", last_cnt[3], 1);

        // re-request while flow 3 is issuing: accepted, served twice, no drop
        clear_cnt();
        cyc(8'h08); cyc(8'h00); cyc(8'h00); cyc(8'h08); cyc(8'h00);
        wait_idle();
        check("reissue_drop", drop, 16'd1);
        check("reissue_flow3_hdrs", last_cnt[3], 2);
        check("reissue_beats", wr_cnt, 8);

        // bank toggled mid-header
        exp_q = '{6'h04, 6'h05, 6'h06, 6'h07, 6'h34, 6'h35, 6'h36, 6'h37};
        sb_en = 1'b1;
        cyc(8'h02); cyc(8'h00); cyc(8'h00);
        @(negedge clk);
        sel = 8'h20;
        shift = 1'b1;
        cyc(8'h00);
        wait_idle();
        sb_en = 1'b0;
        shift = 1'b0;
        check("bank_sb_left", exp_q.size(), 0);

        // wide instance: flow 9, bank 1
        first_rd = -1; first_wr = -1; nrd = 0; nwr = 0;
        shift2 = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            sel2 = (c == 0) ? 16'h0200 : 16'h0000;
            if (rd2) begin
                if (first_rd < 0) first_rd = c;
                check($sformatf("big_addr%0d", nrd), addr2, {1'b1, 4'd9, 3'(nrd)});
                nrd++;
            end
            if (wr2) begin
                if (first_wr < 0) first_wr = c;
                check($sformatf("big_data%0d", nwr), data2, ram_word({1'b1, 4'd9, 3'(nwr)}));
                check($sformatf("big_last%0d", nwr), last2, (nwr == 7));
                check($sformatf("big_flow%0d", nwr), flow2, 4'd9);
                nwr++;
                if (c - first_wr + 1 != nwr) begin
                    n_cmp++; n_bad++;
                    $display("FAIL big_contig: beat %0d at cycle %0d, first at %0d", nwr, c, first_wr);
                end
            end
        end
        shift2 = 1'b0;
        check("big_first_rd", first_rd, 2);
        check("big_wr_latency", first_wr - first_rd, 5);
        check("big_nrd", nrd, 8);
        check("big_nwr", nwr, 8);

        // reset during the second beat of an issue
        clear_cnt();
        cyc(8'h04); cyc(8'h00); cyc(8'h00);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_cnt();
        repeat (20) @(negedge clk);
        check("midrst_no_wr", wr_cnt, 0);
        cyc(8'h10); cyc(8'h00);
        wait_idle();
        check("midrst_flow4_hdrs", last_cnt[4], 1);
        check("midrst_beats", wr_cnt, 4);
        check("midrst_flow2_hdrs", last_cnt[2], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pkt_hdr_reader.md
# pkt_hdr_reader

Parametrised header-read engine in the traffic-generate path. Accepts per-flow send requests from the time-slot scheduler, arbitrates among pending flows, and streams the selected flow's Ethernet header from the double-banked packet-header RAM to the header-editing stage. Unlike its fixed 8-flow, 4-beat predecessor, it handles multi-hot requests, queues requests that arrive while busy, issues reads back-to-back with a configurable RAM latency, and tags output beats with flow ID and last-beat.

## Interface
- FLOW_NUM, 8: number of flows; power of 2, 2..64.
- HDR_BEATS, 4: RAM words per header; power of 2, 1..16.
- DATA_W, 128: RAM word width.
- RD_LAT, 2: RAM read latency in cycles, 1..4. Data is valid RD_LAT cycles after the rd/addr cycle.
- Derived: FID_W = $clog2(FLOW_NUM); BEAT_W = max(1,$clog2(HDR_BEATS)); ADDR_W = 1+FID_W+BEAT_W.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_addr_shift  in  1  active RAM bank from the list-control module.
- in_selected  in  FLOW_NUM  per-flow request pulses from the scheduler; multi-hot allowed.
- out_pkt_hdr_rd  out  1  RAM read enable.
- out_pkt_hdr_addr  out  ADDR_W  {bank, flow, beat}.
- in_pkt_hdr  in  DATA_W  RAM read data.
- out_pkt_hdr  out  DATA_W  header beat to the header-editing stage.
- out_pkt_hdr_wr  out  1  beat valid.
- out_pkt_hdr_last  out  1  final beat of a header.
- out_pkt_hdr_flow  out  FID_W  flow index of the current beat.
- out_busy  out  1  issue in progress or a request pending.
- out_drop_cnt  out  16  saturating count of dropped requests.

## Operation
- Pending vector pend[FLOW_NUM]: each cycle pend <= (pend & ~grant_clr) | in_selected. If a set and a clear hit the same bit in one cycle, the set wins.
- Drop: an in_selected bit whose pend bit is already set and not being cleared that cycle increments out_drop_cnt by 1, saturating at 16'hFFFF. Multiple such bits in one cycle count once.
- FSM states: IDLE and ISSUE.
  - IDLE: if pend != 0, grant one flow, latch flow index and in_addr_shift (bank), clear that pend bit, and go to ISSUE with beat=0.
  - ISSUE: drive rd=1 and addr={bank,flow,beat}; beat increments each cycle.
  - At beat=HDR_BEATS-1: if pend (after this cycle's clear) is nonzero, grant the next flow and stay in ISSUE with beat=0, so there is no bubble. Otherwise go to IDLE.
- Bank is sampled only at grant. A later in_addr_shift change does not affect a header already in flight.
- Read pipeline: a valid/last/flow shift register RD_LAT deep is loaded on every rd cycle. At its tail, in_pkt_hdr is registered into out_pkt_hdr, and wr/last/flow are registered alongside.
- In IDLE: rd=0, addr=0. When wr=0, out_pkt_hdr=0, last=0, flow=0.
- out_busy = (state==ISSUE) | (pend!=0) | (any pipeline valid).

## Timing
- Reset values: all outputs 0; pend=0; pipeline cleared; state IDLE.
- Latency from in_selected pulse (cycle T, IDLE, nothing pending) to first rd: T+2, because pend is registered at T+1 and the grant issues at T+2.
- First out_pkt_hdr_wr: rd cycle + RD_LAT + 1.
- Beats of one header are contiguous: wr is high for HDR_BEATS consecutive cycles, with last on the final beat.
- Back-to-back headers produce a continuous wr stream.
- Reset mid-operation: in-flight beats are discarded, and no partial header is completed after reset release.
- A request for the flow currently being issued is accepted into pend and served later. This is not a drop.

## Configuration
- PHR_RR_ARB_EN defined: round-robin arbitration. Search starts at (last granted index + 1) mod FLOW_NUM; the pointer resets to FLOW_NUM-1, so flow 0 is granted first.
- Not defined: fixed priority, lowest index wins.
- Both modes are otherwise cycle-identical.

## Structure
- Shared package phr_pkg holds:
  - the state enum (IDLE, ISSUE);
  - localparam helpers for FID_W, BEAT_W, ADDR_W;
  - the drop-counter width (16).
- Sub-module phr_arbiter (FLOW_NUM, request vector in, one-hot grant plus index out, RR pointer under PHR_RR_ARB_EN). It is the only natural split. The FSM, pending vector, and read pipeline stay in pkt_hdr_reader.

## Test plan
- Defaults, in_addr_shift=1, in_selected=8'h04 for one cycle:
  - rd high for 4 cycles with addr 6'h28..6'h2B;
  - wr for 4 cycles starting 3 cycles after the first rd;
  - flow=2, last on beat 4, data matches RAM model.
- Multi-hot 8'h81 with PHR_RR_ARB_EN undefined: flow 0 then flow 7, back-to-back (8 consecutive rd and 8 consecutive wr). With PHR_RR_ARB_EN, repeated 8'h81 alternates 0 then 7 in arbitration order.
- Re-request of flow 3 while flow 3 is pending and unserved: out_drop_cnt increments 0 to 1. Re-request while flow 3 is in ISSUE: no drop, and flow 3 is served twice.
- Bank toggled mid-header: all beats of that header use the bank sampled at grant. The next header uses the new bank.
- rst_n asserted during the second beat of issue: all outputs 0 immediately. After release, no wr occurs until a new request arrives.
- Parameter sweep RD_LAT=1 and 4, HDR_BEATS=1 and 8, FLOW_NUM=16: wr latency equals RD_LAT+1 and the address format is {bank,flow,beat}.
